// File: rtl/seg7_rx_pkg.sv
// Shared definitions for the seven-segment receiver: filter FSM encoding and
// the sixteen hex glyphs (bit0=a .. bit6=g, active high).
package seg7_rx_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FILT  = 2'd1,
        ST_LOCK  = 2'd2
    } state_t;

    localparam logic [6:0] GLYPH_0 = 7'h3F;
    localparam logic [6:0] GLYPH_1 = 7'h06;
    localparam logic [6:0] GLYPH_2 = 7'h5B;
    localparam logic [6:0] GLYPH_3 = 7'h4F;
    localparam logic [6:0] GLYPH_4 = 7'h66;
    localparam logic [6:0] GLYPH_5 = 7'h6D;
    localparam logic [6:0] GLYPH_6 = 7'h7D;
    localparam logic [6:0] GLYPH_7 = 7'h07;
    localparam logic [6:0] GLYPH_8 = 7'h7F;
    localparam logic [6:0] GLYPH_9 = 7'h6F;
    localparam logic [6:0] GLYPH_A = 7'h77;
    localparam logic [6:0] GLYPH_B = 7'h7C;
    localparam logic [6:0] GLYPH_C = 7'h39;
    localparam logic [6:0] GLYPH_D = 7'h5E;
    localparam logic [6:0] GLYPH_E = 7'h79;
    localparam logic [6:0] GLYPH_F = 7'h71;

endpackage

// File: rtl/seg7_decode.sv
// Combinational glyph-to-hex decoder; anything that is not one of the sixteen
// glyphs decodes to digit 0 with digit_valid low.
module seg7_decode
    import seg7_rx_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] digit,
    output logic       digit_valid
);

    always_comb begin
        digit       = 4'h0;
        digit_valid = 1'b1;
        case (pattern)
            GLYPH_0: digit = 4'h0;
            GLYPH_1: digit = 4'h1;
            GLYPH_2: digit = 4'h2;
            GLYPH_3: digit = 4'h3;
            GLYPH_4: digit = 4'h4;
            GLYPH_5: digit = 4'h5;
            GLYPH_6: digit = 4'h6;
            GLYPH_7: digit = 4'h7;
            GLYPH_8: digit = 4'h8;
            GLYPH_9: digit = 4'h9;
            GLYPH_A: digit = 4'hA;
            GLYPH_B: digit = 4'hB;
            GLYPH_C: digit = 4'hC;
            GLYPH_D: digit = 4'hD;
            GLYPH_E: digit = 4'hE;
            GLYPH_F: digit = 4'hF;
            default: digit_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_rx.sv
// Seven-segment bus receiver: debounces the observed segment pattern, decodes
// it to hex and keeps change statistics (frame count, change period).
module seg7_rx
    import seg7_rx_pkg::*;
#(
    parameter int STABLE_CYC = 4,
    parameter int PERIOD_BIT = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [6:0]            segments,
    input  logic                  clear,
    output logic [6:0]            pattern,
    output logic [3:0]            digit,
    output logic                  digit_valid,
    output logic                  change_stb,
    output logic [PERIOD_BIT-1:0] period,
    output logic                  period_ovf,
    output logic [7:0]            frame_cnt
);

    localparam logic [7:0]            STAB_LAST = 8'(STABLE_CYC);
    localparam logic [PERIOD_BIT-1:0] PER_MAX   = '1;
    localparam logic [PERIOD_BIT-1:0] PER_ONE   = PERIOD_BIT'(1);

    state_t                state;
    logic [6:0]            seg_q;
    logic [6:0]            cand;
    logic [7:0]            stab_cnt;
    logic                  from_empty;
    logic                  accept;
    logic [PERIOD_BIT-1:0] per_cnt;
    logic [PERIOD_BIT-1:0] per_next;
    logic                  first_chg;

    function automatic logic [PERIOD_BIT-1:0] sat_inc(input logic [PERIOD_BIT-1:0] v);
        return (v == PER_MAX) ? v : v + PER_ONE;
    endfunction

    // Candidate has survived the full window; a re-acquired copy of the held
    // pattern is a rejected glitch unless nothing has been accepted yet.
    assign accept = (state == ST_FILT) && (seg_q == cand) && (stab_cnt == STAB_LAST) &&
                    ((cand != pattern) || from_empty);

    assign per_next = sat_inc(per_cnt);

    // Input register and stability filter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_EMPTY;
            seg_q      <= '0;
            cand       <= '0;
            stab_cnt   <= '0;
            from_empty <= 1'b1;
            pattern    <= '0;
            change_stb <= 1'b0;
        end else begin
            seg_q      <= segments;
            change_stb <= 1'b0;
            case (state)
                ST_EMPTY: begin
                    cand       <= seg_q;
                    stab_cnt   <= 8'd1;
                    from_empty <= 1'b1;
                    state      <= ST_FILT;
                end
                ST_LOCK: begin
                    if (seg_q != pattern) begin
                        cand       <= seg_q;
                        stab_cnt   <= 8'd1;
                        from_empty <= 1'b0;
                        state      <= ST_FILT;
                    end
                end
                ST_FILT: begin
                    if (seg_q != cand) begin
                        cand     <= seg_q;
                        stab_cnt <= 8'd1;
                    end else if (stab_cnt == STAB_LAST) begin
                        state <= ST_LOCK;
                        if (accept) begin
                            pattern    <= cand;
                            change_stb <= 1'b1;
                        end
                    end else begin
                        stab_cnt <= stab_cnt + 8'd1;
                    end
                end
                default: state <= ST_EMPTY;
            endcase
        end
    end

    // Statistics; clear overrides a coincident accept
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            per_cnt    <= '0;
            period     <= '0;
            period_ovf <= 1'b0;
            frame_cnt  <= '0;
            first_chg  <= 1'b0;
        end else if (clear) begin
            per_cnt    <= '0;
            period     <= '0;
            period_ovf <= 1'b0;
            frame_cnt  <= '0;
            first_chg  <= 1'b0;
        end else if (accept) begin
            per_cnt   <= PER_ONE;
            frame_cnt <= frame_cnt + 8'd1;
            if (first_chg) begin
                period <= per_cnt;
            end else begin
                first_chg <= 1'b1;
            end
        end else begin
            per_cnt <= per_next;
            if (per_next == PER_MAX) begin
                period_ovf <= 1'b1;
            end
        end
    end

    seg7_decode u_decode (
        .pattern     (pattern),
        .digit       (digit),
        .digit_valid (digit_valid)
    );

endmodule

// File: tb/tb_seg7_rx.sv
// Directed bench for seg7_rx: every expected strobe is queued when its
// stimulus is driven and checked against the DUT when change_stb appears.
module tb_seg7_rx;
    import seg7_rx_pkg::*;

    localparam int STABLE_CYC = 4;
    localparam int PERIOD_BIT = 8;
    localparam int PMAX       = 255;
    localparam int LAT        = STABLE_CYC + 2;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  clear;
    logic [6:0]            segments;
    logic [6:0]            pattern;
    logic [3:0]            digit;
    logic                  digit_valid;
    logic                  change_stb;
    logic [PERIOD_BIT-1:0] period;
    logic                  period_ovf;
    logic [7:0]            frame_cnt;

    seg7_rx #(.STABLE_CYC(STABLE_CYC), .PERIOD_BIT(PERIOD_BIT)) dut (
        .clk         (clk),
        .reset       (reset),
        .segments    (segments),
        .clear       (clear),
        .pattern     (pattern),
        .digit       (digit),
        .digit_valid (digit_valid),
        .change_stb  (change_stb),
        .period      (period),
        .period_ovf  (period_ovf),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] pat;
        logic [3:0] dig;
        logic       vld;
        int         frame;
        int         per;
        int         due;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Reference model state
    int   m_frame, m_first, m_period, m_ref_val, m_ref_edge;

    logic [6:0] glyph_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    function automatic logic [4:0] ref_decode(input logic [6:0] p);
        for (int i = 0; i < 16; i++)
            if (glyph_tbl[i] == p) return {1'b1, 4'(i)};
        return 5'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [6:0] pat, input int frame, input int per, input int due);
        exp_t       e;
        logic [4:0] d;
        d       = ref_decode(pat);
        e.pat   = pat;
        e.dig   = d[3:0];
        e.vld   = d[4];
        e.frame = frame;
        e.per   = per;
        e.due   = due;
        sb.push_back(e);
    endtask

    task automatic drive_accept(input logic [6:0] pat);
        int due, per_old;
        segments = pat;
        due      = cyc + LAT;
        per_old  = m_ref_val + (due - 1 - m_ref_edge);
        if (per_old > PMAX) per_old = PMAX;
        m_frame = (m_frame + 1) % 256;
        if (m_first != 0) m_period = per_old;
        else m_first = 1;
        m_ref_val  = 1;
        m_ref_edge = due;
        push_exp(pat, m_frame, m_period, due);
    endtask

    task automatic model_zero(input int edge_idx);
        m_frame    = 0;
        m_first    = 0;
        m_period   = 0;
        m_ref_val  = 0;
        m_ref_edge = edge_idx;
    endtask

    task automatic step(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                if (change_stb === 1'b1) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_stb", 32'(change_stb), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("stb_cycle", 32'(cyc), 32'(e.due));
                        chk("stb_pattern", 32'(pattern), 32'(e.pat));
                        chk("stb_digit", 32'(digit), 32'(e.dig));
                        chk("stb_digit_valid", 32'(digit_valid), 32'(e.vld));
                        chk("stb_frame_cnt", 32'(frame_cnt), 32'(e.frame));
                        chk("stb_period", 32'(period), 32'(e.per));
                    end
                end else if (sb.size() > 0 && cyc >= sb[0].due) begin
                    e = sb.pop_front();
                    chk("missed_stb", 32'(change_stb), 32'd1);
                end
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pattern"}, 32'(pattern), 32'd0);
        chk({tag, "_digit"}, 32'(digit), 32'd0);
        chk({tag, "_digit_valid"}, 32'(digit_valid), 32'd0);
        chk({tag, "_change_stb"}, 32'(change_stb), 32'd0);
        chk({tag, "_period"}, 32'(period), 32'd0);
        chk({tag, "_period_ovf"}, 32'(period_ovf), 32'd0);
        chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
    endtask

    initial begin
        int due;
        reset    = 1'b1;
        clear    = 1'b0;
        segments = 7'h06;
        model_zero(0);
        step(3);
        chk_all_zero("reset");

        // First acceptance out of reset
        reset = 1'b0;
        model_zero(cyc);
        drive_accept(7'h06);
        step(10);
        chk("first_digit", 32'(digit), 32'h1);
        chk("first_valid", 32'(digit_valid), 32'd1);
        chk("first_frame", 32'(frame_cnt), 32'd1);
        chk("first_period", 32'(period), 32'd0);

        // Short excursion is rejected
        segments = 7'h5B;
        step(3);
        segments = 7'h06;
        step(12);
        chk("glitch_pattern", 32'(pattern), 32'h06);
        chk("glitch_frame", 32'(frame_cnt), 32'd1);

        // Non-glyph pattern
        drive_accept(7'h49);
        step(12);
        chk("nonglyph_pattern", 32'(pattern), 32'h49);
        chk("nonglyph_valid", 32'(digit_valid), 32'd0);
        chk("nonglyph_digit", 32'(digit), 32'd0);

        // Alternating patterns, 100 cycles each
        for (int i = 0; i < 4; i++) begin
            drive_accept((i % 2 == 0) ? 7'h3F : 7'h4F);
            step(100);
        end
        chk("alt_period", 32'(period), 32'd100);
        chk("alt_ovf", 32'(period_ovf), 32'd0);

        // Every glyph decodes
        for (int i = 0; i < 16; i++) begin
            drive_accept(glyph_tbl[i]);
            step(8);
        end

        // Period saturation and clear
        drive_accept(7'h06);
        step(150);
        chk("ovf_before_sat", 32'(period_ovf), 32'd0);
        step(150);
        chk("ovf_after_sat", 32'(period_ovf), 32'd1);
        drive_accept(7'h5B);
        step(10);
        chk("ovf_sticky", 32'(period_ovf), 32'd1);
        chk("sat_period", 32'(period), 32'(PMAX));
        clear = 1'b1;
        model_zero(cyc + 1);
        step(1);
        clear = 1'b0;
        step(1);
        chk("clear_ovf", 32'(period_ovf), 32'd0);
        chk("clear_frame", 32'(frame_cnt), 32'd0);
        chk("clear_period", 32'(period), 32'd0);
        chk("clear_keeps_pattern", 32'(pattern), 32'h5B);

        // Clear on the same edge as an accept
        segments = 7'h66;
        due      = cyc + LAT;
        push_exp(7'h66, 0, 0, due);
        model_zero(due);
        step(LAT - 1);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        step(5);
        chk("clr_acc_frame", 32'(frame_cnt), 32'd0);
        chk("clr_acc_digit", 32'(digit), 32'h4);

        // Reset in the middle of filtering
        segments = 7'h77;
        step(3);
        chk("midfilt_stab_cnt", 32'(dut.stab_cnt), 32'd2);
        chk("midfilt_state", 32'(dut.state), 32'(ST_FILT));
        reset = 1'b1;
        #1;
        chk_all_zero("midreset");
        chk("midreset_state", 32'(dut.state), 32'(ST_EMPTY));
        step(3);
        segments = 7'h7F;
        reset    = 1'b0;
        model_zero(cyc);
        drive_accept(7'h7F);
        step(20);
        chk("post_reset_pattern", 32'(pattern), 32'h7F);
        chk("post_reset_frame", 32'(frame_cnt), 32'd1);

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
